// File: rtl/vdic_alu_pkg.sv
// vdic_alu_pkg: shared word widths, opcode/status encodings and parity helper for the serial ALU link.
package vdic_alu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_OPERANDS = 8;
  localparam int WORD_W = DEF_DATA_W + 2;
  localparam int RESP_W = 3 * WORD_W;
  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_AND = 8'h01,
    OP_OR  = 8'h02,
    OP_XOR = 8'h03,
    OP_ADD = 8'h10,
    OP_SUB = 8'h20
  } operation_t;
  typedef enum logic [7:0] {
    S_NONE                 = 8'h00,
    S_MISSING_DATA         = 8'h01,
    S_DATA_STACK_OVERFLOW  = 8'h02,
    S_OUTPUT_FIFO_OVERFLOW = 8'h04,
    S_DATA_PARITY_ERROR    = 8'h20,
    S_COMMAND_PARITY_ERROR = 8'h40,
    S_INVALID_COMMAND      = 8'h80
  } status_t;
  // Even-parity bit over type + payload; the input side expects its inverse.
  function automatic logic word_parity(input logic [WORD_W-2:0] bits);
    return ^bits;
  endfunction
endpackage

// File: rtl/alu_word_serializer.sv
// alu_word_serializer: 30-bit PISO that frames status/result as three parity-tagged words on dout.
module alu_word_serializer
  import vdic_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     status,
  input  logic [2*DATA_W-1:0]   result,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  done
);
  localparam int N = 3 * (DATA_W + 2);
  localparam int CW = $clog2(N);
  logic [N-1:0] sh;
  logic [CW-1:0] cnt;
  logic [N-1:0] frame;
  assign frame = {1'b1, status, word_parity({1'b1, status}),
                  1'b0, result[2*DATA_W-1:DATA_W], word_parity({1'b0, result[2*DATA_W-1:DATA_W]}),
                  1'b0, result[DATA_W-1:0], word_parity({1'b0, result[DATA_W-1:0]})};
  assign dout = dout_valid & sh[N-1];
  assign done = dout_valid && cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      sh <= frame;
      cnt <= '0;
      dout_valid <= 1'b1;
    end else if (dout_valid) begin
      sh <= sh << 1;
      cnt <= cnt + 1'b1;
      if (done) dout_valid <= 1'b0;
    end
endmodule

// File: rtl/serial_alu_responder.sv
// serial_alu_responder: deserialises operand/command words, folds the stacked operands and
// answers with a status/result frame through alu_word_serializer.
module serial_alu_responder
  import vdic_alu_pkg::*;
#(
  parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);
  localparam int CW = $clog2(MAX_OPERANDS + 1);
  localparam int IW = $clog2(MAX_OPERANDS);
  localparam int BW = $clog2(DATA_W + 2);
  localparam logic [1:0] IDLE = 2'd0, RX = 2'd1, EXEC = 2'd2, TX = 2'd3;
  logic [1:0] state, state_n;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W:0] sh;
  logic [DATA_W-1:0] stack_d [MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] stack_bad;
  logic [CW-1:0] depth;
  logic dovf, fovf, cmd_bad, load, tx_done;
  logic [7:0] opcode;
  logic [DATA_W-1:0] status_n, status_q;
  logic [2*DATA_W-1:0] acc, opd, result_q;
  logic word_done, word_ok, accept, is_cmd, is_nop, exec_go, invalid;
  assign word_done = !enable_n && bit_cnt == BW'(DATA_W + 1);
  assign word_ok = ^{sh, din};
  assign accept = word_done && (state == IDLE || state == RX);
  assign is_cmd = sh[DATA_W];
  assign is_nop = word_ok && sh[DATA_W-1:0] == '0;
  assign exec_go = accept && is_cmd && !is_nop;
  assign invalid = !(opcode inside {OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB});
  assign status_n = (depth < CW'(2) ? S_MISSING_DATA : S_NONE)
                  | (dovf ? S_DATA_STACK_OVERFLOW : S_NONE)
                  | (fovf ? S_OUTPUT_FIFO_OVERFLOW : S_NONE)
                  | (|stack_bad ? S_DATA_PARITY_ERROR : S_NONE)
                  | (cmd_bad ? S_COMMAND_PARITY_ERROR : S_NONE)
                  | (invalid ? S_INVALID_COMMAND : S_NONE);
  always_comb begin
    acc = {{DATA_W{1'b0}}, stack_d[0]};
    opd = '0;
    for (int i = 1; i < MAX_OPERANDS; i++) begin
      opd = {{DATA_W{1'b0}}, stack_d[i]};
      if (CW'(i) < depth)
        acc = opcode == OP_AND ? acc & opd :
              opcode == OP_OR  ? acc | opd :
              opcode == OP_XOR ? acc ^ opd :
              opcode == OP_ADD ? acc + opd : acc - opd;
    end
  end
  always_comb
    state_n = exec_go ? EXEC :
              (state == IDLE || state == RX) ? (enable_n ? IDLE : RX) :
              state == EXEC ? TX : (tx_done ? IDLE : TX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      for (int i = 0; i < MAX_OPERANDS; i++) stack_d[i] <= '0;
      stack_bad <= '0;
      depth <= '0;
      dovf <= 1'b0;
      fovf <= 1'b0;
      cmd_bad <= 1'b0;
      opcode <= '0;
      status_q <= '0;
      result_q <= '0;
      load <= 1'b0;
    end else begin
      state <= state_n;
      load <= state == EXEC;
      bit_cnt <= (enable_n || word_done) ? '0 : bit_cnt + 1'b1;
      if (!enable_n && !word_done) sh <= {sh[DATA_W-1:0], din};
      if (accept && !is_cmd) begin
        if (depth == CW'(MAX_OPERANDS)) dovf <= 1'b1;
        else begin
          stack_d[depth[IW-1:0]] <= sh[DATA_W-1:0];
          stack_bad[depth[IW-1:0]] <= !word_ok;
          depth <= depth + 1'b1;
        end
      end
      if (accept && is_cmd) begin
        opcode <= 8'(sh[DATA_W-1:0]);
        cmd_bad <= !word_ok;
      end
      if (state == EXEC) begin
        status_q <= status_n;
        result_q <= status_n != '0 ? '0 : acc;
      end
      if (state == EXEC || (accept && is_cmd && is_nop)) begin
        depth <= '0;
        stack_bad <= '0;
        dovf <= 1'b0;
        fovf <= 1'b0;
      end
      // Words completing while busy are lost; flag them for the next response.
      if (word_done && (state == EXEC || state == TX)) fovf <= 1'b1;
    end
  alu_word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .status(status_q),
    .result(result_q),
    .dout(dout),
    .dout_valid(dout_valid),
    .done(tx_done)
  );
endmodule

// File: tb/tb_serial_alu_responder.sv
// tb_serial_alu_responder: directed serial packets with a queue-based scoreboard on the response frames.
module tb_serial_alu_responder;
  import vdic_alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, enable_n = 1'b1, din = 1'b0;
  logic dout, dout_valid;
  int errors = 0, checks = 0, nbit = 0;
  logic [29:0] frame = '0;
  logic [23:0] exp_q[$];
  always #5 clk = ~clk;
  serial_alu_responder dut (
    .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .din(din),
    .dout(dout), .dout_valid(dout_valid)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial forever begin
    logic [23:0] e;
    @(negedge clk);
    if (!rst_n) nbit = 0;
    else if (dout_valid) begin
      frame = {frame[28:0], dout};
      nbit++;
      if (nbit == 30) begin
        nbit = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h expected no response", frame);
        end else begin
          e = exp_q.pop_front();
          check("status", 32'(frame[28:21]), 32'(e[23:16]));
          check("result", 32'({frame[18:11], frame[8:1]}), 32'(e[15:0]));
          check("type_bits", 32'({frame[29], frame[19], frame[9]}), 32'b100);
          check("even_parity", 32'({^frame[29:20], ^frame[19:10], ^frame[9:0]}), 32'b000);
        end
      end
    end
  end
  task automatic send_word(input logic typ, input logic [7:0] pl, input logic flip);
    logic [9:0] w;
    w = {typ, pl, ~word_parity({typ, pl}) ^ flip};
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      enable_n = 1'b0;
      din = w[i];
    end
  endtask
  task automatic end_frame();
    @(negedge clk);
    enable_n = 1'b1;
    din = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || nbit != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic cmd(input logic [7:0] op, input logic [7:0] st, input logic [15:0] res);
    exp_q.push_back({st, res});
    send_word(1'b1, op, 1'b0);
    end_frame();
    drain();
  endtask
  initial begin
    #12;
    check("reset_dout_valid", 32'(dout_valid), 0);
    check("reset_dout", 32'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_word(0, 8'h10, 0); send_word(0, 8'h20, 0); send_word(0, 8'h30, 0);
    cmd(OP_ADD, 8'h00, 16'h0060);
    send_word(0, 8'hF0, 0); send_word(0, 8'h3C, 0);
    cmd(OP_AND, 8'h00, 16'h0030);
    send_word(0, 8'h05, 0); send_word(0, 8'h07, 0);
    cmd(OP_SUB, 8'h00, 16'hFFFE);
    send_word(0, 8'h0F, 0); send_word(0, 8'hF0, 0); send_word(0, 8'h01, 0);
    cmd(OP_OR, 8'h00, 16'h00FF);
    send_word(0, 8'hFF, 0); send_word(0, 8'h0F, 0);
    cmd(OP_XOR, 8'h00, 16'h00F0);
    send_word(0, 8'h11, 0); send_word(0, 8'h22, 0);
    cmd(8'hB3, 8'h80, 16'h0000);
    send_word(0, 8'h11, 0); send_word(0, 8'h22, 1);
    cmd(OP_ADD, 8'h20, 16'h0000);
    for (int i = 0; i < 9; i++) send_word(0, 8'(i + 1), 0);
    cmd(OP_ADD, 8'h02, 16'h0000);
    send_word(0, 8'h42, 0);
    cmd(OP_ADD, 8'h01, 16'h0000);
    send_word(0, 8'h05, 0);
    send_word(1, OP_NOP, 0);
    end_frame();
    repeat (40) @(negedge clk);
    send_word(0, 8'h07, 0);
    cmd(OP_ADD, 8'h01, 16'h0000);
    // A word sent during the response is dropped and flagged in the following one.
    send_word(0, 8'h01, 0); send_word(0, 8'h02, 0);
    exp_q.push_back({8'h00, 16'h0003});
    send_word(1, OP_ADD, 0);
    send_word(0, 8'h55, 0);
    end_frame();
    drain();
    send_word(0, 8'h03, 0); send_word(0, 8'h04, 0);
    cmd(OP_ADD, 8'h04, 16'h0000);
    send_word(0, 8'h01, 0); send_word(0, 8'h02, 0); send_word(1, OP_ADD, 0);
    end_frame();
    begin
      int t = 0;
      while (nbit != 12 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checks++;
        errors++;
        $display("FAIL tx_start_timeout: got %0d bits expected 12", nbit);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_dout_valid", 32'(dout_valid), 0);
    check("abort_dout", 32'(dout), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_word(0, 8'h01, 0); send_word(0, 8'h01, 0);
    cmd(OP_ADD, 8'h00, 16'h0002);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/serial_alu_responder.md
# serial_alu_responder

Serial-protocol ALU responder for the 2022 lab bench; the device end of the one-bit packet link the testbench drives.
- Deserialises 10-bit words from `din` while `enable_n` is low and stacks data operands.
- On a command word, folds the stacked operands with the requested operation.
- Returns a 3-word serial response (status, result high, result low) on `dout` framed by `dout_valid`.
- Serves as a synthesizable reference model, and as a stand-in DUT for bring-up of the bench's sequence and scoreboard code.

## Interface
- `MAX_OPERANDS`, 8: data-word stack depth.
- `DATA_W`, 8: payload bits per word; result width is 2*DATA_W.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable_n` input 1: active-low frame enable; `din` is sampled only when 0.
- `din` input 1: serial input, one bit per posedge.
- `dout` output 1: serial response bit.
- `dout_valid` output 1: high while a response bit is on `dout`.

## Operation
- Word format, first bit to last:
  - bit0 type (1 = command, 0 = data).
  - bits1-8 payload, MSB first.
  - bit9 parity.
- Input words: odd parity, XOR of all 10 bits = 1.
- Output words: even parity, bit9 = XOR of bits0-8.
- Opcodes, in `payload`: NOP 0x00, AND 0x01, OR 0x02, XOR 0x03, ADD 0x10, SUB 0x20. Any other value is invalid.
- Data word:
  - Pushed onto the stack with its parity flag.
  - A push when the stack is full sets the sticky `S_DATA_STACK_OVERFLOW`; the word is dropped.
- Command word, result rules:
  - `r = zero-extended op0`, then `r = r op opN` for each remaining operand in arrival order.
  - ADD and SUB are modulo 2^16.
  - AND, OR and XOR are bitwise on the zero-extended value.
- Status byte bits:
  - `S_MISSING_DATA` 0x01: fewer than 2 operands.
  - `S_DATA_STACK_OVERFLOW` 0x02.
  - `S_OUTPUT_FIFO_OVERFLOW` 0x04: a word arrived while a response was being shifted out; that word is discarded.
  - `S_DATA_PARITY_ERROR` 0x20: any stacked operand had bad parity.
  - `S_COMMAND_PARITY_ERROR` 0x40.
  - `S_INVALID_COMMAND` 0x80.
- Any status bit set: result = 0x0000. Multiple error bits may be set together.
- NOP: no response is sent; the stack and sticky flags are cleared.
- After each response: the stack and sticky flags are cleared, except `S_OUTPUT_FIFO_OVERFLOW`, which is reported in the next response.
- Response words, in order:
  - W0 = {1, status, p}.
  - W1 = {0, result[15:8], p}.
  - W2 = {0, result[7:0], p}.
- FSM states:
  - `IDLE` -> `RX`: on the first posedge with `enable_n`=0.
  - `RX` -> `IDLE`: `enable_n`=1 before the command word completes. The partial word is discarded; the stack is kept.
  - `RX` -> `EXEC`: after a command word's bit9.
  - `EXEC` -> `TX`: after one cycle.
  - `TX` -> `IDLE`: after 30 bits.

## Timing
- Reset values:
  - `dout`=0, `dout_valid`=0.
  - FSM in `IDLE`, stack empty, bit counter 0, all flags clear.
- Reset asserted mid-RX or mid-TX aborts immediately. Outputs return to their reset values asynchronously.
- Bit counter:
  - Counts 0..9 per word and wraps to 0 after bit9.
  - `enable_n` high resets it to 0.
- Latency: command bit9 is sampled at posedge N; `dout_valid` and W0 bit0 are driven after posedge N+2.
- TX:
  - One bit per cycle for exactly 30 cycles, updated after each posedge.
  - `dout_valid` drops after the 30th bit; `dout` returns to 0.
  - A consumer sampling `dout` on posedge while `dout_valid`=1 receives all 30 bits.
- During `EXEC` and `TX`, `din` bits are not stacked. Any completed word sets the overflow flag described above.

## Structure
- Shared package `vdic_alu_pkg`:
  - `status_t`, `operation_t`.
  - Word-width constants.
  - Parity helper function, shared with the bench.
- Sub-module `alu_word_serializer`:
  - 30-bit PISO with load strobe, bit counter and `dout_valid` generation.
  - Parity bits are inserted at load time.
- Top-level content: deserialiser, operand stack, fold ALU, FSM.

## Test plan
- ADD 0x10, 0x20, 0x30 -> status 0x00, result 0x0060, all three words even parity.
- AND 0xF0, 0x3C -> status 0x00, result 0x0030. SUB 0x05, 0x07 -> result 0xFFFE.
- Command payload 0xB3 after 2 operands -> status 0x80, result 0x0000.
- Second operand sent with a flipped parity bit, then ADD -> status 0x20, result 0x0000.
- 9 operands then ADD -> status 0x02. A single operand then ADD -> status 0x01.
- `rst_n` pulsed low at TX bit 12 -> `dout_valid`=0 immediately. A following ADD 0x01, 0x01 -> status 0x00, result 0x0002.
